// File: rtl/gprs_wr_arbiter_pkg.sv
// Shared constants and types for the GPR write-port arbiter and its users.
// The register file is 8 x 16-bit with a single write port.
package gprs_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Requester index assignment on the arbiter's request vector.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_HOST = 2'd2
    } wb_src_e;

endpackage

// File: rtl/gprs_wr_arbiter_if.sv
// Writeback request and register-reservation handshakes into the arbiter.
// Valid/ready rule: a transfer happens on a rising edge where valid && ready; ready may depend on valid combinationally.
interface gprs_wr_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = gprs_pkg::DATA_W,
    parameter int ADDR_W = gprs_pkg::ADDR_W
) ();

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][ADDR_W-1:0] req_ws;
    logic [NREQ-1:0][DATA_W-1:0] req_wd;

    logic                        rsv_valid;
    logic [ADDR_W-1:0]           rsv_ws;
    logic                        rsv_ready;

    modport master (
        output req_valid, req_ws, req_wd, rsv_valid, rsv_ws,
        input  req_ready, rsv_ready
    );

    modport slave (
        input  req_valid, req_ws, req_wd, rsv_valid, rsv_ws,
        output req_ready, rsv_ready
    );

endinterface

// File: rtl/gprs_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// The pointer moves only when the caller reports a completed handshake.
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_grant;
    logic             found;
    int               idx;

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= IDX_W'(N - 1);
        else if (advance)
            last_grant <= grant_idx;
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gprs_wr_arbiter.sv
// Shares the register file write port between writeback requesters and
// tracks outstanding destination registers for read-after-write hazard detection.
module gprs_wr_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = gprs_pkg::DATA_W,
    parameter int ADDR_W = gprs_pkg::ADDR_W,
    parameter int NREGS  = gprs_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    gprs_wr_if.slave          bus,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              we,
    output logic [ADDR_W-1:0] ws,
    output logic [DATA_W-1:0] wd,
    output logic [NREGS-1:0]  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             hs;
    logic             rsv_take;
    logic [NREGS-1:0] busy_nxt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req_valid),
        .advance   (hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant;
    assign hs            = |(bus.req_valid & grant);

    assign bus.rsv_ready = ~busy[bus.rsv_ws];
    assign rsv_take      = bus.rsv_valid & bus.rsv_ready;
    assign hazard1       = busy[rs1];
    assign hazard2       = busy[rs2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we <= 1'b0;
            ws <= '0;
            wd <= '0;
        end else begin
            we <= hs;
            if (hs) begin
                ws <= bus.req_ws[grant_idx];
                wd <= bus.req_wd[grant_idx];
            end
        end
    end

    // Clear lands on the same edge the register file captures wd; a new
    // reservation of that register on that edge must survive, so set is applied last.
    always_comb begin
        busy_nxt = busy;
        if (we)
            busy_nxt[ws] = 1'b0;
        if (rsv_take)
            busy_nxt[bus.rsv_ws] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: tb/tb_gprs_wr_arbiter.sv
// Directed bench for gprs_wr_arbiter: grants, scoreboard bits and the
// registered write port are checked against an expected-write queue.
module tb_gprs_wr_arbiter;
    import gprs_pkg::*;

    localparam int NREQ = 3;
    localparam int W    = ADDR_W + DATA_W;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rs1, rs2;
    logic              hazard1, hazard2;
    logic              we;
    logic [ADDR_W-1:0] ws;
    logic [DATA_W-1:0] wd;
    logic [NREGS-1:0]  busy;

    gprs_wr_if #(.NREQ(NREQ)) bus ();

    gprs_wr_arbiter #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .rs1     (rs1),
        .rs2     (rs2),
        .hazard1 (hazard1),
        .hazard2 (hazard2),
        .we      (we),
        .ws      (ws),
        .wd      (wd),
        .busy    (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the write port must carry exactly the queued write.
    task automatic tick();
        logic [W-1:0] e;
        logic         exp_we;
        @(posedge clk);
        @(negedge clk);
        exp_we = (exp_q.size() != 0);
        check("we", {31'd0, we}, {31'd0, exp_we});
        if (exp_we) begin
            e = exp_q.pop_front();
            if (we)
                check("write_port", {13'd0, ws, wd}, {13'd0, e});
        end
    endtask

    // Driver tasks
    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_ws[i] = a;
        bus.req_wd[i] = d;
    endtask

    task automatic drive_req(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] exp_grant);
        bus.req_valid = valid;
        #1;
        check("req_ready", {29'd0, bus.req_ready}, {29'd0, exp_grant});
        for (int i = 0; i < NREQ; i++)
            if (exp_grant[i] && valid[i])
                exp_q.push_back({bus.req_ws[i], bus.req_wd[i]});
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_ws    = '0;
        bus.req_wd    = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_ws    = '0;
        rs1           = '0;
        rs2           = '0;
        tick();
        tick();
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_ws", {29'd0, ws}, 32'd0);
        check("rst_wd", {16'd0, wd}, 32'd0);
        check("rst_busy", {24'd0, busy}, 32'd0);
        reset = 1'b1;

        // Round robin from reset: 0, 1, 2.
        set_req(WB_ALU,  3'd1, 16'h1111);
        set_req(WB_LOAD, 3'd2, 16'h2222);
        set_req(WB_HOST, 3'd4, 16'h4444);
        drive_req(3'b111, 3'b001); tick();
        drive_req(3'b111, 3'b010); tick();
        drive_req(3'b111, 3'b100); tick();
        drive_req(3'b000, 3'b000); tick();

        // Idle cycles must not move the pointer.
        drive_req(3'b010, 3'b010); tick();
        drive_req(3'b000, 3'b000); tick();
        drive_req(3'b010, 3'b010); tick();
        drive_req(3'b111, 3'b100); tick();
        drive_req(3'b000, 3'b000);

        // Reserve R5, then the load unit writes it.
        bus.rsv_valid = 1'b1;
        bus.rsv_ws    = 3'd5;
        #1 check("rsv_ready_free", {31'd0, bus.rsv_ready}, 32'd1);
        tick();
        bus.rsv_valid = 1'b0;
        rs1 = 3'd5;
        rs2 = 3'd4;
        #1;
        check("busy_r5", {24'd0, busy}, 32'h20);
        check("hazard1_r5", {31'd0, hazard1}, 32'd1);
        check("hazard2_r4", {31'd0, hazard2}, 32'd0);
        check("rsv_ready_busy", {31'd0, bus.rsv_ready}, 32'd0);
        set_req(WB_LOAD, 3'd5, 16'hBEEF);
        drive_req(3'b010, 3'b010); tick();
        drive_req(3'b000, 3'b000);
        check("busy_during_we", {24'd0, busy}, 32'h20);
        check("hazard_during_we", {31'd0, hazard1}, 32'd1);
        tick();
        #1;
        check("busy_cleared", {24'd0, busy}, 32'h00);
        check("hazard_cleared", {31'd0, hazard1}, 32'd0);

        // Same-edge set and clear on R3: set wins.
        bus.rsv_valid = 1'b1;
        bus.rsv_ws    = 3'd3;
        tick();
        bus.rsv_valid = 1'b0;
        set_req(WB_ALU, 3'd3, 16'h3333);
        drive_req(3'b001, 3'b001); tick();
        check("busy_r3", {24'd0, busy}, 32'h08);
        set_req(WB_ALU, 3'd3, 16'h3334);
        bus.rsv_valid = 1'b1;
        drive_req(3'b001, 3'b001);
        check("rsv_ready_r3_busy", {31'd0, bus.rsv_ready}, 32'd0);
        tick();
        drive_req(3'b000, 3'b000);
        check("busy_r3_cleared", {24'd0, busy}, 32'h00);
        check("rsv_ready_r3_free", {31'd0, bus.rsv_ready}, 32'd1);
        tick();
        bus.rsv_valid = 1'b0;
        check("set_wins", {24'd0, busy}, 32'h08);

        // Build busy = A5 with a write in flight, then reset mid-operation.
        set_req(WB_ALU, 3'd3, 16'h0033);
        bus.rsv_valid = 1'b1;
        bus.rsv_ws    = 3'd0;
        drive_req(3'b001, 3'b001); tick();
        bus.rsv_ws = 3'd2;
        drive_req(3'b000, 3'b000); tick();
        bus.rsv_ws = 3'd5;
        tick();
        bus.rsv_ws = 3'd7;
        set_req(WB_LOAD, 3'd6, 16'h6666);
        drive_req(3'b010, 3'b010); tick();
        bus.rsv_valid = 1'b0;
        bus.req_valid = '0;
        check("busy_a5", {24'd0, busy}, 32'hA5);
        check("we_before_reset", {31'd0, we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, we}, 32'd0);
        check("mid_rst_ws", {29'd0, ws}, 32'd0);
        check("mid_rst_busy", {24'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        drive_req(3'b111, 3'b001); tick();

        // Back-to-back writes from the host port, no bubbles.
        for (int i = 0; i < 8; i++) begin
            set_req(WB_HOST, 3'(i), 16'($urandom_range(0, 16'hFFFF)));
            drive_req(3'b100, 3'b100);
            tick();
        end
        drive_req(3'b000, 3'b000);
        tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
